x_metadata_loader: RTL and testbench
====================================

# x_metadata_loader

Fetches the X-row bitmap from memory, one META_CHUNK_SIZE-bit chunk at a time, through an HCI streamer source. It holds the current chunk stable for Y_data_scheduler, which consumes it on `metadata_chunk` and requests more through its `meta_used_o`/`meta_used_i` pair. The block sits directly upstream of Y_data_scheduler. It owns chunk addressing, beat assembly, last-chunk masking and the request/ready handshake.

## Interface
- META_CHUNK_SIZE, 512, chunk width in bits (multiple of MEM_BUS_WIDTH)
- MEM_BUS_WIDTH, 32, streamer beat width in bits
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous soft clear (same effect as reset)
- params_i  in  X_meta_param_t  base_address[31:0], n_chunks[15:0], last_chunk_bits[15:0]
- meta_req_i  in  1  scheduler's `meta_used_o`; high = scheduler wants a chunk
- meta_pending_o  out  1  drives scheduler's `meta_used_i`; high = no fresh chunk available
- metadata_o  out  META_CHUNK_SIZE  current chunk, drives `metadata_chunk`
- config_o  out  hci_streamer_ctrl_t  streamer source configuration
- data_i  in  MEM_BUS_WIDTH  streamer beat
- data_valid_i  in  1  beat valid
- data_ready_o  out  1  beat ready

## Operation
- BEATS = META_CHUNK_SIZE/MEM_BUS_WIDTH; CHUNK_BYTES = META_CHUNK_SIZE/8.
- Storage: fill buffer, output register `metadata_o`, beat counter, chunk index `chunk_q` (16 b), and `fresh_q` (fill buffer complete and not yet handed over).
- FSM states:
  - IDLE: waits for a fetch trigger.
  - ISSUE: 1 cycle. Drives `config_o.req_start`=1; base_addr = base_address + chunk_q*CHUNK_BYTES; tot_len = d0_len = BEATS; d0_stride = MEM_BUS_WIDTH/8. Goes to FILL.
  - FILL: `data_ready_o`=1. Each valid beat j writes fill[j*MEM_BUS_WIDTH +: MEM_BUS_WIDTH]. After beat BEATS-1, sets fresh_q and goes to FULL.
  - FULL: holds the fill buffer until accept.
- Fill masking: when chunk_q == n_chunks-1, fill bits at index ≥ last_chunk_bits are forced to 0. last_chunk_bits == 0 means a full chunk.
- Accept: meta_req_i && fresh_q in the same cycle.
  - metadata_o ← fill buffer.
  - fresh_q ← 0.
  - chunk_q ← chunk_q+1; wraps to 0 after n_chunks-1.
- Fetch trigger (demand mode): state IDLE, fresh_q == 0, meta_req_i == 1.
- `meta_pending_o` = ~fresh_q (registered).
- Accept and beat arrival in the same cycle cannot happen, because accept requires fresh_q=1, which only exists in FULL.
- n_chunks == 0: the block stays in IDLE and meta_pending_o stays 1.

## Timing
- Reset/clear values:
  - state IDLE, fresh_q 0, chunk_q 0.
  - metadata_o 0, config_o 0, data_ready_o 0, meta_pending_o 1.
- `config_o` is registered. req_start is high for exactly the ISSUE cycle; all other fields hold until the next ISSUE.
- Latency:
  - meta_req_i rising to ISSUE: 1 cycle.
  - Last beat to meta_pending_o low: 1 cycle.
  - Accept to new metadata_o visible: the next cycle, which is the first cycle the scheduler uses the chunk.
- metadata_o changes only on accept.
- data_valid_i outside FILL is ignored (ready is low).
- Reset or clear mid-FILL: the partial chunk is discarded and the block restarts at chunk 0. The streamer must be cleared alongside.

## Configuration
- `X_METADATA_PREFETCH_EN`:
  - Defined: an accept also triggers an immediate fetch of the next chunk (IDLE→ISSUE the cycle after accept), regardless of meta_req_i. After reset, the first fetch still waits for meta_req_i.
  - Undefined: demand mode only; a fetch starts only when meta_req_i is high with fresh_q low.

## Structure
- `X_meta_param_t` goes in accelerator_package, next to `Y_param_t`.
- The FSM state enum goes in accelerator_package.
- The beat-assembly/masking datapath is one sub-module, `meta_chunk_assembler`: beat counter, fill buffer, mask, done pulse. The FSM, handshake and addressing stay in the top.

## Test plan
- Reset, n_chunks=2, base 0x1000, meta_req_i=1 → req_start pulse with base_addr 0x1000, tot_len 16, d0_stride 4. After 16 beats, meta_pending_o falls 1 cycle after the last beat.
- With pending low and meta_req_i high → metadata_o equals the assembled beats the next cycle; meta_pending_o returns to 1.
- Second chunk, last_chunk_bits=100 → bits 100..511 of metadata_o are 0; chunk_q wraps and the next base_addr is 0x1000.
- data_valid_i toggled randomly during FILL → the beat order is preserved and no beat is lost or duplicated.
- rst_i asserted after 7 beats → all outputs return to reset values; the next request fetches chunk 0 again.
- With `X_METADATA_PREFETCH_EN`, accept chunk 0 → ISSUE for 0x1040 the next cycle with meta_req_i low. Without it → no ISSUE until meta_req_i rises.

Source files
------------

// File: rtl/accelerator_package.sv
// Shared types for the accelerator: X-metadata parameters, streamer control word
// and the X-metadata loader state encoding.
package accelerator_package;

    typedef struct packed {
        logic [31:0] base_address;
        logic [15:0] n_chunks;
        logic [15:0] last_chunk_bits;
    } X_meta_param_t;

    typedef struct packed {
        logic        req_start;
        logic [31:0] base_addr;
        logic [31:0] tot_len;
        logic [31:0] d0_len;
        logic [31:0] d0_stride;
    } hci_streamer_ctrl_t;

    typedef enum logic [1:0] {
        XM_IDLE,
        XM_ISSUE,
        XM_FILL,
        XM_FULL
    } x_meta_state_e;

endpackage

// File: rtl/meta_chunk_assembler.sv
// Assembles streamer beats into one metadata chunk, zeroing bits beyond the
// valid length of the last chunk; done_o flags the beat that completes the chunk.
module meta_chunk_assembler #(
    parameter int META_CHUNK_SIZE = 512,
    parameter int MEM_BUS_WIDTH   = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       en_i,
    input  logic                       data_valid_i,
    input  logic [MEM_BUS_WIDTH-1:0]   data_i,
    input  logic                       mask_en_i,
    input  logic [15:0]                last_bits_i,
    output logic [META_CHUNK_SIZE-1:0] fill_o,
    output logic                       done_o
);
    localparam int BEATS = META_CHUNK_SIZE / MEM_BUS_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_W-1:0]           beat_cnt_q;
    logic                       beat_fire;
    logic [MEM_BUS_WIDTH-1:0]   beat_masked;
    logic [META_CHUNK_SIZE-1:0] fill_q;

    // last_bits == 0 encodes a full last chunk, so nothing is masked then
    function automatic logic [MEM_BUS_WIDTH-1:0] mask_beat(
        input logic [MEM_BUS_WIDTH-1:0] data,
        input logic [CNT_W-1:0]         cnt,
        input logic                     en,
        input logic [15:0]              last_bits
    );
        logic [MEM_BUS_WIDTH-1:0] m;
        logic [31:0]              idx;
        m = data;
        for (int k = 0; k < MEM_BUS_WIDTH; k++) begin
            idx = 32'(cnt) * 32'(MEM_BUS_WIDTH) + 32'(k);
            if (en && (last_bits != 16'd0) && (idx >= {16'd0, last_bits})) begin
                m[k] = 1'b0;
            end
        end
        return m;
    endfunction

    assign beat_fire   = en_i & data_valid_i;
    assign done_o      = beat_fire && (beat_cnt_q == CNT_W'(BEATS - 1));
    assign beat_masked = mask_beat(data_i, beat_cnt_q, mask_en_i, last_bits_i);
    assign fill_o      = fill_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_cnt_q <= '0;
        end else if (clear_i) begin
            beat_cnt_q <= '0;
        end else if (beat_fire) begin
            beat_cnt_q <= done_o ? '0 : beat_cnt_q + 1'b1;
        end
    end

    // Every bit is rewritten before the chunk is handed over, so no reset needed
    always_ff @(posedge clk_i) begin
        if (beat_fire) begin
            fill_q[int'(beat_cnt_q)*MEM_BUS_WIDTH +: MEM_BUS_WIDTH] <= beat_masked;
        end
    end

endmodule

// File: rtl/x_metadata_loader.sv
// Fetches X-row bitmap chunks through an HCI streamer and hands them to Y_data_scheduler.
// Optional X_METADATA_PREFETCH_EN: each accept immediately starts fetching the next chunk.
module x_metadata_loader
    import accelerator_package::*;
#(
    parameter int META_CHUNK_SIZE = 512,
    parameter int MEM_BUS_WIDTH   = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  X_meta_param_t              params_i,
    input  logic                       meta_req_i,
    output logic                       meta_pending_o,
    output logic [META_CHUNK_SIZE-1:0] metadata_o,
    output hci_streamer_ctrl_t         config_o,
    input  logic [MEM_BUS_WIDTH-1:0]   data_i,
    input  logic                       data_valid_i,
    output logic                       data_ready_o
);
    localparam int BEATS       = META_CHUNK_SIZE / MEM_BUS_WIDTH;
    localparam int CHUNK_BYTES = META_CHUNK_SIZE / 8;

    x_meta_state_e              state_q;
    logic [15:0]                chunk_q;
    logic [15:0]                chunk_next;
    logic                       fresh_q;
    logic                       is_last;
    logic                       accept;
    logic                       fill_done;
    logic [META_CHUNK_SIZE-1:0] fill;

    function automatic hci_streamer_ctrl_t issue_cfg(input logic [31:0] base,
                                                     input logic [15:0] idx);
        hci_streamer_ctrl_t c;
        c.req_start = 1'b1;
        c.base_addr = base + 32'(idx) * 32'(CHUNK_BYTES);
        c.tot_len   = 32'(BEATS);
        c.d0_len    = 32'(BEATS);
        c.d0_stride = 32'(MEM_BUS_WIDTH / 8);
        return c;
    endfunction

    assign is_last    = (chunk_q == params_i.n_chunks - 16'd1);
    assign chunk_next = is_last ? 16'd0 : chunk_q + 16'd1;
    assign accept     = meta_req_i & fresh_q;

    meta_chunk_assembler #(
        .META_CHUNK_SIZE(META_CHUNK_SIZE),
        .MEM_BUS_WIDTH  (MEM_BUS_WIDTH)
    ) u_assembler (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .en_i        (data_ready_o),
        .data_valid_i(data_valid_i),
        .data_i      (data_i),
        .mask_en_i   (is_last),
        .last_bits_i (params_i.last_chunk_bits),
        .fill_o      (fill),
        .done_o      (fill_done)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= XM_IDLE;
            chunk_q        <= '0;
            fresh_q        <= 1'b0;
            metadata_o     <= '0;
            config_o       <= '0;
            data_ready_o   <= 1'b0;
            meta_pending_o <= 1'b1;
        end else if (clear_i) begin
            state_q        <= XM_IDLE;
            chunk_q        <= '0;
            fresh_q        <= 1'b0;
            metadata_o     <= '0;
            config_o       <= '0;
            data_ready_o   <= 1'b0;
            meta_pending_o <= 1'b1;
        end else begin
            config_o.req_start <= 1'b0;
            if (accept) begin
                metadata_o     <= fill;
                fresh_q        <= 1'b0;
                meta_pending_o <= 1'b1;
                chunk_q        <= chunk_next;
            end
            case (state_q)
                XM_IDLE: begin
                    if (!fresh_q && meta_req_i && (params_i.n_chunks != 16'd0)) begin
                        state_q  <= XM_ISSUE;
                        config_o <= issue_cfg(params_i.base_address, chunk_q);
                    end
                end
                XM_ISSUE: begin
                    state_q      <= XM_FILL;
                    data_ready_o <= 1'b1;
                end
                XM_FILL: begin
                    if (fill_done) begin
                        state_q        <= XM_FULL;
                        fresh_q        <= 1'b1;
                        meta_pending_o <= 1'b0;
                        data_ready_o   <= 1'b0;
                    end
                end
                XM_FULL: begin
                    if (accept) begin
`ifdef X_METADATA_PREFETCH_EN
                        state_q  <= XM_ISSUE;
                        config_o <= issue_cfg(params_i.base_address, chunk_next);
`else
                        state_q  <= XM_IDLE;
`endif
                    end
                end
                default: state_q <= XM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_x_metadata_loader.sv
// Bench for x_metadata_loader: behavioural streamer/memory plus chunk reference model.
module tb_x_metadata_loader;
    import accelerator_package::*;

    localparam int MCS   = 512;
    localparam int MBW   = 32;
    localparam int BEATS = MCS / MBW;

    logic               clk = 1'b0;
    logic               rst_i;
    logic               clear_i;
    X_meta_param_t      params;
    logic               meta_req_i;
    logic               meta_pending_o;
    logic [MCS-1:0]     metadata_o;
    hci_streamer_ctrl_t config_o;
    logic [MBW-1:0]     data_i;
    logic               data_valid_i;
    logic               data_ready_o;

    int tests = 0;
    int fails = 0;
    int exp_idx = 0;

    x_metadata_loader #(.META_CHUNK_SIZE(MCS), .MEM_BUS_WIDTH(MBW)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .params_i(params),
        .meta_req_i(meta_req_i), .meta_pending_o(meta_pending_o),
        .metadata_o(metadata_o), .config_o(config_o), .data_i(data_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3 ^ (a >> 7);
    endfunction

    function automatic logic [31:0] exp_base(input int c);
        return params.base_address + 32'(c) * 32'(MCS / 8);
    endfunction

    // Chunk c is BEATS consecutive words; the last chunk keeps only its first last_chunk_bits bits
    function automatic logic [MCS-1:0] exp_chunk(input int c);
        logic [MCS-1:0] r;
        for (int j = 0; j < BEATS; j++) r[j*MBW +: MBW] = mem_word(exp_base(c) + 32'(4 * j));
        if (c == int'(params.n_chunks) - 1 && params.last_chunk_bits != 16'd0)
            for (int b = int'(params.last_chunk_bits); b < MCS; b++) r[b] = 1'b0;
        return r;
    endfunction

    // Streamer model: address pointer and remaining beats, cleared with the DUT
    logic [31:0] s_ptr = '0;
    int s_rem = 0;
    int beat_cnt = 0;
    int last_cnt = 0;
    always @(posedge clk) begin
        if (rst_i || clear_i) s_rem <= 0;
        else if (config_o.req_start) begin
            s_ptr <= config_o.base_addr;
            s_rem <= int'(config_o.tot_len);
        end else if (data_valid_i && data_ready_o && s_rem > 0) begin
            s_ptr    <= s_ptr + 32'd4;
            s_rem    <= s_rem - 1;
            beat_cnt <= beat_cnt + 1;
            if (s_rem == 1) last_cnt <= last_cnt + 1;
        end
    end

    initial begin
        data_valid_i = 1'b0;
        data_i = '0;
        forever begin
            @(negedge clk);
            if (s_rem > 0) begin
                data_valid_i = ($urandom_range(0, 9) < 6);
                data_i = mem_word(s_ptr);
            end else begin
                data_valid_i = ($urandom_range(0, 3) == 0);
                data_i = $urandom;
            end
        end
    end

    task automatic do_reset();
        meta_req_i = 1'b0;
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        exp_idx = 0;
        @(negedge clk);
    endtask

    task automatic fetch_accept(input string tag);
        int lc0, lc_before;
        bit ok;
        logic [MCS-1:0] prev;
        meta_req_i = 1'b1;
        prev = metadata_o;
        lc0 = last_cnt;
        lc_before = last_cnt;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            lc_before = last_cnt;
            @(negedge clk);
            if (config_o.req_start) begin
                tests++;
                if (config_o.base_addr !== exp_base(exp_idx)) begin
                    fails++;
                    $display("FAIL %s issue base: got %h expected %h", tag, config_o.base_addr, exp_base(exp_idx));
                end
            end
            if (!meta_pending_o) begin ok = 1; break; end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s fill timeout: pending still %b expected 0", tag, meta_pending_o);
        end
        tests++;
        if (!(lc_before == lc0 && last_cnt == lc0 + 1)) begin
            fails++;
            $display("FAIL %s pending latency: last beats %0d/%0d expected %0d/%0d", tag, lc_before, last_cnt, lc0, lc0 + 1);
        end
        tests++;
        if (metadata_o !== prev) begin
            fails++;
            $display("FAIL %s metadata before accept: got %h expected %h", tag, metadata_o, prev);
        end
        @(negedge clk);
        tests++;
        if (metadata_o !== exp_chunk(exp_idx)) begin
            fails++;
            $display("FAIL %s chunk %0d: got %h expected %h", tag, exp_idx, metadata_o, exp_chunk(exp_idx));
        end
        tests++;
        if (meta_pending_o !== 1'b1) begin
            fails++;
            $display("FAIL %s pending after accept: got %b expected 1", tag, meta_pending_o);
        end
        exp_idx = (exp_idx + 1) % int'(params.n_chunks);
`ifdef X_METADATA_PREFETCH_EN
        tests++;
        if (config_o.req_start !== 1'b1 || config_o.base_addr !== exp_base(exp_idx)) begin
            fails++;
            $display("FAIL %s prefetch issue: got %b/%h expected 1/%h", tag, config_o.req_start, config_o.base_addr, exp_base(exp_idx));
        end
`endif
        meta_req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (meta_pending_o !== 1'b1) begin fails++; $display("FAIL reset pending: got %b expected 1", meta_pending_o); end
        tests++;
        if (metadata_o !== '0) begin fails++; $display("FAIL reset metadata: got %h expected 0", metadata_o); end
        tests++;
        if (data_ready_o !== 1'b0) begin fails++; $display("FAIL reset ready: got %b expected 0", data_ready_o); end
        tests++;
        if (config_o !== hci_streamer_ctrl_t'(0)) begin fails++; $display("FAIL reset config: got %h expected 0", config_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_n_zero();
        bit seen = 0;
        bit pend_ok = 1;
        params = '{base_address: 32'h1000, n_chunks: 16'd0, last_chunk_bits: 16'd0};
        do_reset();
        meta_req_i = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (config_o.req_start) seen = 1;
            if (meta_pending_o !== 1'b1) pend_ok = 0;
        end
        meta_req_i = 1'b0;
        tests++;
        if (seen) begin fails++; $display("FAIL n_zero issue: got req_start 1 expected 0"); end
        tests++;
        if (!pend_ok) begin fails++; $display("FAIL n_zero pending: got 0 expected 1"); end
    endtask

    task automatic test_first_chunk();
        int lc0, lc_before;
        bit ok = 0;
        params = '{base_address: 32'h1000, n_chunks: 16'd2, last_chunk_bits: 16'd100};
        do_reset();
        meta_req_i = 1'b1;
        @(negedge clk);
        tests++;
        if (config_o.req_start !== 1'b1 || config_o.base_addr !== 32'h1000) begin
            fails++; $display("FAIL first issue: got %b/%h expected 1/00001000", config_o.req_start, config_o.base_addr);
        end
        tests++;
        if (config_o.tot_len !== 32'd16 || config_o.d0_len !== 32'd16 || config_o.d0_stride !== 32'd4) begin
            fails++; $display("FAIL first lengths: got %0d/%0d/%0d expected 16/16/4", config_o.tot_len, config_o.d0_len, config_o.d0_stride);
        end
        meta_req_i = 1'b0;
        @(negedge clk);
        tests++;
        if (config_o.req_start !== 1'b0) begin fails++; $display("FAIL req_start width: got 1 expected 0"); end
        lc0 = last_cnt;
        lc_before = last_cnt;
        for (int i = 0; i < 400; i++) begin
            lc_before = last_cnt;
            @(negedge clk);
            if (!meta_pending_o) begin ok = 1; break; end
        end
        tests++;
        if (!ok || lc_before != lc0 || last_cnt != lc0 + 1) begin
            fails++; $display("FAIL first pending latency: got ok=%0d beats %0d/%0d expected 1 %0d/%0d", ok, lc_before, last_cnt, lc0, lc0 + 1);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (metadata_o !== '0 || meta_pending_o !== 1'b0) begin
            fails++; $display("FAIL hold without req: got pend %b meta %h expected 0 and zero", meta_pending_o, metadata_o);
        end
        meta_req_i = 1'b1;
        @(negedge clk);
        tests++;
        if (metadata_o !== exp_chunk(0) || meta_pending_o !== 1'b1) begin
            fails++; $display("FAIL first accept: got %h pend %b expected %h pend 1", metadata_o, meta_pending_o, exp_chunk(0));
        end
        exp_idx = 1;
`ifdef X_METADATA_PREFETCH_EN
        tests++;
        if (config_o.req_start !== 1'b1 || config_o.base_addr !== 32'h1040) begin
            fails++; $display("FAIL prefetch issue: got %b/%h expected 1/00001040", config_o.req_start, config_o.base_addr);
        end
        meta_req_i = 1'b0;
`else
        meta_req_i = 1'b0;
        ok = 0;
        repeat (5) begin
            @(negedge clk);
            if (config_o.req_start) ok = 1;
        end
        tests++;
        if (ok) begin fails++; $display("FAIL demand idle: got req_start 1 expected 0"); end
        meta_req_i = 1'b1;
        @(negedge clk);
        tests++;
        if (config_o.req_start !== 1'b1 || config_o.base_addr !== 32'h1040) begin
            fails++; $display("FAIL demand issue: got %b/%h expected 1/00001040", config_o.req_start, config_o.base_addr);
        end
        meta_req_i = 1'b0;
`endif
    endtask

    task automatic test_mask_wrap();
        logic [MCS-101:0] hi;
        fetch_accept("mask_chunk1");
        hi = metadata_o[MCS-1:100];
        tests++;
        if (hi !== '0) begin fails++; $display("FAIL mask bits: got %h expected 0", hi); end
        fetch_accept("wrap_chunk0");
    endtask

    task automatic test_abort(input bit use_clear);
        int b0;
        bit ok = 0;
        params = '{base_address: 32'h2000, n_chunks: 16'd3, last_chunk_bits: 16'd0};
        do_reset();
        fetch_accept(use_clear ? "pre_clear" : "pre_reset");
        meta_req_i = 1'b1;
        b0 = beat_cnt;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (beat_cnt - b0 == 7) begin ok = 1; break; end
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL abort wait: got %0d beats expected 7", beat_cnt - b0); end
        meta_req_i = 1'b0;
        if (use_clear) clear_i = 1'b1; else rst_i = 1'b1;
        @(negedge clk);
        tests++;
        if (meta_pending_o !== 1'b1 || metadata_o !== '0 || data_ready_o !== 1'b0 || config_o !== hci_streamer_ctrl_t'(0)) begin
            fails++; $display("FAIL abort state (clear=%0d): got pend %b ready %b meta %h expected 1 0 zero", use_clear, meta_pending_o, data_ready_o, metadata_o);
        end
        clear_i = 1'b0;
        rst_i = 1'b0;
        exp_idx = 0;
        @(negedge clk);
        fetch_accept(use_clear ? "after_clear" : "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 3; it++) begin
            params.n_chunks        = 16'($urandom_range(1, 4));
            params.last_chunk_bits = (it == 0) ? 16'd0 : 16'($urandom_range(1, MCS - 1));
            params.base_address    = $urandom & 32'hFFFF_FFC0;
            do_reset();
            for (int k = 0; k < int'(params.n_chunks) + 2; k++) fetch_accept("b2b");
        end
    endtask

    initial begin
        rst_i = 1'b1;
        clear_i = 1'b0;
        meta_req_i = 1'b0;
        params = '0;
        test_reset();
        test_n_zero();
        test_first_chunk();
        test_mask_wrap();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
